detector_jogada: RTL and testbench

//   Input conditioner placed directly upstream of the game datapath/control unit.

---
 rtl/detector_jogada_if.sv | 29 ++
 rtl/detector_jogada.sv | 117 +++++++++++
 tb/tb_detector_jogada.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/detector_jogada_if.sv
// Button-side bus of the move detector: raw buttons and enable in, accepted move out.
// jogada_feita is a valid strobe without ready: jogada/jogada_valida are meaningful
// whenever jogada_feita is high, the consumer cannot stall it, and it lasts one cycle.
interface detector_jogada_if;
    logic       habilita;
    logic [3:0] botoes;
    logic       jogada_feita;
    logic [3:0] jogada;
    logic       jogada_valida;
    logic [2:0] db_estado;

    modport master (
        output habilita,
        output botoes,
        input  jogada_feita,
        input  jogada,
        input  jogada_valida,
        input  db_estado
    );

    modport slave (
        input  habilita,
        input  botoes,
        output jogada_feita,
        output jogada,
        output jogada_valida,
        output db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM and one registered
// jogada_feita pulse per physical press, carrying the latched 4-bit button code.
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic               clock,
    input  logic               reset,
    detector_jogada_if.slave   bus
);

    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        FILTRA = 3'd1,
        ACEITA = 3'd2,
        SOLTA  = 3'd3
    } estado_t;

    // Bound stays <= 254 for the legal parameter range, so the 8-bit counter never wraps.
    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CICLOS - 1);

    logic [3:0] r_s1;
    logic [3:0] r_s2;
    estado_t    r_estado;
    logic [3:0] r_amostra;
    logic [7:0] r_cnt;
    logic [3:0] r_jogada;
    logic       r_jogada_valida;

    estado_t    w_prox_estado;
    logic [3:0] w_amostra_prox;
    logic [7:0] w_cnt_prox;
    logic       w_aceita;
    logic       w_onehot;

    assign w_onehot = (r_amostra != 4'd0) && ((r_amostra & (r_amostra - 4'd1)) == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1            <= 4'd0;
            r_s2            <= 4'd0;
            r_estado        <= ESPERA;
            r_amostra       <= 4'd0;
            r_cnt           <= 8'd0;
            r_jogada        <= 4'd0;
            r_jogada_valida <= 1'b0;
        end else begin
            r_s1      <= bus.botoes;
            r_s2      <= r_s1;
            r_estado  <= w_prox_estado;
            r_amostra <= w_amostra_prox;
            r_cnt     <= w_cnt_prox;
            if (w_aceita) begin
                r_jogada        <= r_amostra;
                r_jogada_valida <= w_onehot;
            end
        end
    end

    always_comb begin
        w_prox_estado  = ESPERA;
        w_amostra_prox = r_amostra;
        w_cnt_prox     = r_cnt;
        w_aceita       = 1'b0;
        case (r_estado)
            ESPERA: begin
                // Enable only gates the start of a press; one already filtering completes.
                if ((r_s2 != 4'd0) && bus.habilita) begin
                    w_prox_estado  = FILTRA;
                    w_amostra_prox = r_s2;
                    w_cnt_prox     = 8'd0;
                end else begin
                    w_prox_estado = ESPERA;
                end
            end
            FILTRA: begin
                if (r_s2 == 4'd0) begin
                    w_prox_estado = ESPERA;
                end else if (r_s2 != r_amostra) begin
                    w_prox_estado  = FILTRA;
                    w_amostra_prox = r_s2;
                    w_cnt_prox     = 8'd0;
                end else if (r_cnt == CNT_MAX) begin
                    w_prox_estado = ACEITA;
                    w_aceita      = 1'b1;
                end else begin
                    w_prox_estado = FILTRA;
                    w_cnt_prox    = r_cnt + 8'd1;
                end
            end
            ACEITA: begin
                w_prox_estado = SOLTA;
                w_cnt_prox    = 8'd0;
            end
            SOLTA: begin
                // A held button restarts the release filter, so there is no auto-repeat.
                if (r_s2 != 4'd0) begin
                    w_prox_estado = SOLTA;
                    w_cnt_prox    = 8'd0;
                end else if (r_cnt == CNT_MAX) begin
                    w_prox_estado = ESPERA;
                end else begin
                    w_prox_estado = SOLTA;
                    w_cnt_prox    = r_cnt + 8'd1;
                end
            end
            default: w_prox_estado = ESPERA;
        endcase
    end

    always_comb begin
        bus.jogada_feita  = (r_estado == ACEITA);
        bus.jogada        = r_jogada;
        bus.jogada_valida = r_jogada_valida;
        bus.db_estado     = r_estado;
    end

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada: expected pulses (cycle, validity, code) are queued
// by the stimulus and popped by a monitor whenever jogada_feita is seen.
module tb_detector_jogada;

    localparam int D = 4;
    localparam int W = 37;

    logic clock = 1'b0;
    logic reset;

    detector_jogada_if bus();

    detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at the negedge where the press first appears: the first sampling edge is
    // cyc+1 and the pulse is visible after edge cyc+1+2+D.
    task automatic expect_pulse(input logic [3:0] code, input logic valida);
        exp_q.push_back({32'(cyc + D + 3), valida, code});
    endtask

    task automatic press(input logic [3:0] code, input int n);
        bus.botoes = code;
        repeat (n) @(negedge clock);
        bus.botoes = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        bus.habilita = 1'b1;
        bus.botoes   = 4'd0;
        reset        = 1'b1;
        fork
            begin : monitor
                logic [W-1:0] e;
                forever begin
                    @(posedge clock);
                    #1;
                    if (bus.jogada_feita === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_pulse: got pulse jogada=%b at cycle %0d, expected no pulse",
                                     bus.jogada, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("pulse_cycle", 32'(cyc), e[36:5]);
                            chk("pulse_jogada", 32'(bus.jogada), 32'(e[3:0]));
                            chk("pulse_valida", 32'(bus.jogada_valida), 32'(e[4]));
                        end
                    end
                end
            end
            begin : stimulus
                @(negedge clock);
                reset = 1'b0;
                chk("rst_feita", 32'(bus.jogada_feita), 32'd0);
                chk("rst_jogada", 32'(bus.jogada), 32'd0);
                chk("rst_valida", 32'(bus.jogada_valida), 32'd0);
                chk("rst_estado", 32'(bus.db_estado), 32'd0);
                idle(2);

                // Clean single-button press
                expect_pulse(4'b0010, 1'b1);
                press(4'b0010, 10);
                idle(10);
                chk("clean_jogada", 32'(bus.jogada), 32'b0010);
                chk("clean_valida", 32'(bus.jogada_valida), 32'd1);
                chk("clean_idle_estado", 32'(bus.db_estado), 32'd0);

                // Bounce, then stable hold
                for (int i = 0; i < 6; i++) begin
                    bus.botoes = (i % 2 == 0) ? 4'b0100 : 4'b0000;
                    @(negedge clock);
                end
                expect_pulse(4'b0100, 1'b1);
                press(4'b0100, 10);
                idle(10);

                // Short glitch and a press exactly one cycle too short
                press(4'b0001, 3);
                idle(10);
                chk("glitch_jogada", 32'(bus.jogada), 32'b0100);
                press(4'b0010, D);
                idle(10);
                chk("short_jogada", 32'(bus.jogada), 32'b0100);

                // Minimum accepted width
                expect_pulse(4'b1000, 1'b1);
                press(4'b1000, D + 1);
                idle(10);
                chk("minw_jogada", 32'(bus.jogada), 32'b1000);

                // Two buttons held for 50 cycles
                expect_pulse(4'b0101, 1'b0);
                bus.botoes = 4'b0101;
                repeat (25) @(negedge clock);
                chk("held_estado_mid", 32'(bus.db_estado), 32'd3);
                repeat (25) @(negedge clock);
                bus.botoes = 4'd0;
                repeat (5) @(negedge clock);
                chk("held_estado_rel5", 32'(bus.db_estado), 32'd3);
                @(negedge clock);
                chk("held_estado_rel6", 32'(bus.db_estado), 32'd0);
                chk("held_jogada", 32'(bus.jogada), 32'b0101);
                chk("held_valida", 32'(bus.jogada_valida), 32'd0);

                // Gated press
                bus.habilita = 1'b0;
                press(4'b1000, 10);
                idle(10);
                bus.habilita = 1'b1;
                idle(2);
                chk("gate_jogada", 32'(bus.jogada), 32'b0101);
                chk("gate_estado", 32'(bus.db_estado), 32'd0);

                // Reset in the middle of filtering, button still held
                bus.botoes = 4'b0001;
                repeat (2) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("midrst_estado", 32'(bus.db_estado), 32'd0);
                chk("midrst_jogada", 32'(bus.jogada), 32'd0);
                chk("midrst_valida", 32'(bus.jogada_valida), 32'd0);
                chk("midrst_feita", 32'(bus.jogada_feita), 32'd0);
                expect_pulse(4'b0001, 1'b1);
                repeat (10) @(negedge clock);
                bus.botoes = 4'd0;
                idle(10);
                chk("midrst_jogada_after", 32'(bus.jogada), 32'b0001);

                for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clock);
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
